// File: rtl/serial_tx_pkg.sv
// ============================================================================
//  serial_tx_pkg : shared types and constants for the serial_tx_8 word shifter
//  Revision      : 1.0
// ============================================================================
`default_nettype none

package serial_tx_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } tx_state_e;

    localparam int DEFAULT_WIDTH = 8;

    // A one-bit word still needs a one-bit counter register.
    function automatic int cnt_width(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/tx_bit_counter.sv
// ============================================================================
//  tx_bit_counter : loadable down-counter that tracks bits left in a word
//  Revision       : 1.0
// ============================================================================
`default_nettype none

module tx_bit_counter #(
    parameter int WIDTH = 3
) (
    input  logic             c,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             dec,
    output logic             zero
);

    logic [WIDTH-1:0] count;

    // Load wins over decrement so a back-to-back word restarts the count.
    always_ff @(posedge c) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (dec && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

`default_nettype wire

// File: rtl/serial_tx_8.sv
// ============================================================================
//  serial_tx_8 : parallel-in, serial-out word transmitter with ready/valid
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module serial_tx_8
    import serial_tx_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter int MSB_FIRST = 1
) (
    input  logic             c,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    input  logic             valid,
    output logic             ready,
    output logic             sout,
    output logic             busy,
    output logic             last
);

    localparam int             CW       = cnt_width(WIDTH);
    localparam logic [CW-1:0]  LAST_IDX = CW'(WIDTH - 1);

    tx_state_e        state;
    tx_state_e        state_next;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] shreg_next;
    logic [WIDTH-1:0] shifted;
    logic             out_bit;
    logic             cnt_zero;
    logic             cnt_dec;
    logic             handshake;

    generate
        if (MSB_FIRST != 0) begin : g_msb_first
            assign out_bit = shreg[WIDTH-1];
            assign shifted = shreg << 1;
        end else begin : g_lsb_first
            assign out_bit = shreg[0];
            assign shifted = shreg >> 1;
        end
    endgenerate

    assign busy      = (state == SHIFT);
    assign ready     = (state == IDLE) || cnt_zero;
    assign last      = busy && cnt_zero;
    assign sout      = busy && out_bit;
    assign handshake = valid && ready;

    always_comb begin
        state_next = state;
        shreg_next = shreg;
        cnt_dec    = 1'b0;
        case (state)
            IDLE: begin
                if (handshake) begin
                    state_next = SHIFT;
                    shreg_next = din;
                end
            end
            SHIFT: begin
                if (handshake) begin
                    shreg_next = din;
                end else if (cnt_zero) begin
                    state_next = IDLE;
                    shreg_next = '0;
                end else begin
                    shreg_next = shifted;
                    cnt_dec    = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
                shreg_next = '0;
            end
        endcase
    end

    always_ff @(posedge c) begin
        if (reset) begin
            state <= IDLE;
            shreg <= '0;
        end else begin
            state <= state_next;
            shreg <= shreg_next;
        end
    end

    tx_bit_counter #(
        .WIDTH (CW)
    ) u_bit_counter (
        .c          (c),
        .reset      (reset),
        .load       (handshake),
        .load_value (LAST_IDX),
        .dec        (cnt_dec),
        .zero       (cnt_zero)
    );

endmodule

`default_nettype wire

// File: doc/serial_tx_8.md
SERIAL_TX_8 -- requirements
Module: serial_tx_8

Interface
REQ-001 Parameter WIDTH, default 8, number of bits per word.
REQ-002 Parameter MSB_FIRST, default 1; 1 = MSB sent first, 0 = LSB sent first.
REQ-003 c  input  1  clock; all state changes on its rising edge.
REQ-004 reset  input  1  reset; synchronous and active-high.
REQ-005 din  input  WIDTH  parallel word to transmit.
REQ-006 valid  input  1  din is offered for transmission.
REQ-007 ready  output  1  block accepts a word at the next rising edge of c.
REQ-008 sout  output  1  serial data bit, one bit per c cycle.
REQ-009 busy  output  1  a word is being shifted out.
REQ-010 last  output  1  sout currently carries the final bit of the word.

Function
REQ-011 FSM SHALL have two states: IDLE and SHIFT.
REQ-012 Handshake SHALL occur on a rising edge of c with valid=1 and ready=1; din is captured into the shift register only at a handshake.
REQ-013 ready SHALL be 1 in IDLE, and in SHIFT only while the bit counter is 0; it SHALL be 0 otherwise.
REQ-014 At a handshake, the block SHALL load the shift register with din, set the counter to WIDTH-1 and enter SHIFT.
REQ-015 In SHIFT, sout SHALL equal the register MSB (MSB_FIRST=1) or LSB (MSB_FIRST=0), with no combinational path from din or valid.
REQ-016 On each edge in SHIFT without a handshake and with counter > 0, the register SHALL shift one place toward the output end (zero-filled) and the counter SHALL decrement.
REQ-017 The first bit SHALL appear on sout in the cycle after the handshake edge; a word SHALL occupy exactly WIDTH consecutive cycles.
REQ-018 last SHALL be 1 exactly when the state is SHIFT and the counter is 0.
REQ-019 busy SHALL be 1 exactly when the state is SHIFT.
REQ-020 With counter 0 and a handshake, the block SHALL load the new word and stay in SHIFT (back-to-back, no gap cycle); with counter 0 and no handshake, it SHALL return to IDLE.
REQ-021 In IDLE, sout SHALL be 0.
REQ-022 valid=1 while ready=0 SHALL be ignored; there is no buffering, and the offer is not remembered.
REQ-023 Changes to din outside a handshake SHALL have no effect on sout.

Reset
REQ-024 When reset=1 at a rising edge of c, the block SHALL enter IDLE, clear the register and counter, and abort any word in progress without finishing it.
REQ-025 After that edge, the outputs SHALL be ready=1, sout=0, busy=0, last=0.
REQ-026 reset SHALL take priority over a simultaneous handshake; the offered word is discarded.

Structure
REQ-027 Package serial_tx_pkg SHALL hold the state enum typedef (IDLE, SHIFT) and the default width constant (8).
REQ-028 The down-counter SHALL be a sub-module tx_bit_counter, with load, decrement and zero-flag ports and a width of clog2(WIDTH).
REQ-029 Counter width SHALL be clog2(WIDTH); for WIDTH=1, every word has last=1 in its only cycle.

Verification
REQ-030 Single word: MSB_FIRST=1, handshake with din=8'hA5 -> sout=1,0,1,0,0,1,0,1 over 8 cycles; busy=1 for 8 cycles; last=1 on the 8th cycle only; then IDLE with sout=0.
REQ-031 Back-to-back: 8'hA5, then valid held with 8'h3C during the last cycle -> 16 contiguous bits 10100101 00111100; busy never drops; last pulses on cycles 8 and 16.
REQ-032 Reset mid-word: reset=1 on the 4th bit of 8'hFF -> next cycle sout=0, busy=0, last=0, ready=1; the remaining bits are never sent.
REQ-033 Ignored offer: valid=1 with din=8'h00 during bits 2-6 of 8'hF0 -> sout follows 11110000 unchanged; no second word is sent.
REQ-034 LSB-first: MSB_FIRST=0, din=8'h01 -> sout=1 then seven 0s; last=1 on the 8th cycle.
REQ-035 Reset priority: reset=1 and a handshake of 8'hAA on the same edge -> IDLE, sout stays 0, no bits sent.
